// File: rtl/key_event_pkg.sv
// Shared definitions for the key event detector.
//   - key_state_e         : press-classification FSM encoding (IDLE, PRESSED, HELD)
//   - DEBOUNCE_CYCLES_DEF : default debounce window, 20 ms at 50 MHz
//   - LONG_CYCLES_DEF     : default long-press threshold, 2 s at 50 MHz
//   - cnt_width()         : counter width for a cycle count, never below 1 bit
package key_event_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned LONG_CYCLES_DEF     = 100000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } key_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_event_detector_if.sv
// Key event bus: raw button in, debounced level and event strobes out.
//   KEY_n       : raw push-button, active-low, asynchronous to the clock
//   key_level   : debounced key state, 1 = pressed
//   short_pulse : one-cycle strobe on release of a short press
//   long_pulse  : one-cycle strobe when a hold reaches the long threshold
// master = button/consumer side, slave = detector side.
interface key_event_detector_if;

    logic KEY_n;
    logic key_level;
    logic short_pulse;
    logic long_pulse;

    modport master (
        output KEY_n,
        input  key_level,
        input  short_pulse,
        input  long_pulse
    );

    modport slave (
        input  KEY_n,
        output key_level,
        output short_pulse,
        output long_pulse
    );

endinterface

// File: rtl/key_debounce.sv
// Synchronizer plus debouncer for an active-low push-button.
//   CLOCK_50  : system clock, rising edge
//   RESET_n   : asynchronous active-low reset
//   KEY_n     : raw button, active-low, asynchronous
//   key_level : debounced level, 1 = pressed
// A new level is accepted once the synchronized input has disagreed with
// key_level for DEBOUNCE_CYCLES consecutive cycles, giving an edge on
// key_level 2+DEBOUNCE_CYCLES cycles after the KEY_n edge. Shorter glitches
// clear the counter and leave key_level untouched.
module key_debounce
    import key_event_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic CLOCK_50,
    input  logic RESET_n,
    input  logic KEY_n,
    output logic key_level
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          pressed_sync;
    logic [CW-1:0] stable_cnt_q, stable_cnt_d;
    logic          level_q, level_d;

    // Synchronizer resets to the released level so a key held through
    // reset is seen as a fresh press.
    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= KEY_n;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_sync = ~sync2_q;

    // Counter tracks how long the synchronized level has held a value
    // different from key_level; agreement keeps it at zero.
    always_comb begin
        stable_cnt_d = '0;
        level_d      = level_q;
        if (pressed_sync != level_q) begin
            if (stable_cnt_q == STABLE_LAST) begin
                level_d = pressed_sync;
            end else begin
                stable_cnt_d = stable_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            stable_cnt_q <= '0;
            level_q      <= 1'b0;
        end else begin
            stable_cnt_q <= stable_cnt_d;
            level_q      <= level_d;
        end
    end

    assign key_level = level_q;

endmodule

// File: rtl/key_event_detector.sv
// Push-button event detector: debounced level, short-press and long-press strobes.
//   CLOCK_50 : system clock, rising edge
//   RESET_n  : asynchronous active-low reset
//   kbus     : key_event_detector_if.slave (KEY_n in; key_level, short_pulse,
//              long_pulse out)
// Build option KEY_LONGPRESS_EN: when defined, a hold of LONG_CYCLES debounced
// cycles fires long_pulse and suppresses the short_pulse on release. When not
// defined, the hold counter and HELD state are absent, long_pulse is 0 and
// every release fires short_pulse.
module key_event_detector
    import key_event_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_n,
    key_event_detector_if.slave   kbus
);

    // Hold terminal is detected as "next count equals LONG_CYCLES-1", which
    // needs at least two cycles of hold.
    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2) begin : g_bad_params
        $error("key_event_detector: DEBOUNCE_CYCLES must be >= 1, LONG_CYCLES >= 2");
    end

    logic       key_level;
    key_state_e state_q, state_d;
    logic       short_q, short_d;
    logic       long_q, long_d;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLOCK_50  (CLOCK_50),
        .RESET_n   (RESET_n),
        .KEY_n     (kbus.KEY_n),
        .key_level (key_level)
    );

`ifdef KEY_LONGPRESS_EN
    localparam int unsigned HW = cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
`endif

    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        long_d  = 1'b0;
`ifdef KEY_LONGPRESS_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (key_level) begin
                    state_d = PRESSED;
`ifdef KEY_LONGPRESS_EN
                    hold_d  = '0;
`endif
                end
            end
            PRESSED: begin
`ifdef KEY_LONGPRESS_EN
                hold_d = hold_q + 1'b1;
                // Terminal count wins over a simultaneous release.
                if (hold_d == HOLD_LAST) begin
                    long_d  = 1'b1;
                    state_d = HELD;
                end else if (!key_level) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
`else
                if (!key_level) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
`ifdef KEY_LONGPRESS_EN
            HELD: begin
                // Counter is frozen here; release is silent.
                if (!key_level) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

`ifdef KEY_LONGPRESS_EN
    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign kbus.long_pulse = long_q;
`else
    assign kbus.long_pulse = 1'b0;
`endif

    assign kbus.key_level   = key_level;
    assign kbus.short_pulse = short_q;

endmodule
